// File: rtl/fifo_rd_pkg.sv
// Shared state encoding, sizing helper and output-buffer geometry
// for the FIFO burst read controller.
package fifo_rd_pkg;

    localparam int OBUF_DEPTH = 4;
    localparam int OBUF_PW    = 2;
    localparam int OBW        = OBUF_PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Ceiling log2; sizes the FIFO usedw port from DEPTH.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO-side status/read signals and the downstream word stream
// of the burst read controller.
interface fifo_rd_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);

    logic             fifo_empty;
    logic             fifo_full;
    logic [AW-1:0]    fifo_usedw;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        input  fifo_empty,
        input  fifo_full,
        input  fifo_usedw,
        input  fifo_q,
        input  flush,
        input  out_ready,
        output fifo_rd,
        output out_valid,
        output out_data,
        output out_last,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_full,
        output fifo_usedw,
        output fifo_q,
        output flush,
        output out_ready,
        input  fifo_rd,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  busy
    );

endinterface

// File: rtl/fifo_rd_obuf.sv
// Four-entry in-order output buffer; each entry carries a word
// plus its end-of-burst marker.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [OBW-1:0]   count
);

    localparam logic [OBW-1:0] FULL_CNT = OBW'(OBUF_DEPTH);

    logic [WIDTH:0]       mem [OBUF_DEPTH];
    logic [OBUF_PW-1:0]   wr_ptr;
    logic [OBUF_PW-1:0]   rd_ptr;
    logic                 push;
    logic                 pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr][WIDTH-1:0];
    assign out_last  = out_valid && mem[rd_ptr][WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_last, in_data};
                wr_ptr      <= wr_ptr + OBUF_PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + OBUF_PW'(1);
            end
            // Push and pop together leave the occupancy unchanged.
            unique case ({push, pop})
                2'b10:   count <= count + OBW'(1);
                2'b01:   count <= count - OBW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: drains a synchronous FIFO in BURST-word
// bursts (or a short flush burst) into a valid/ready stream.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_rd_ctrl_if.master bus
);

    localparam int AW = clogb2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  BURST_C = CW'(BURST);
    localparam logic [OBW-1:0] OB_FULL = OBW'(OBUF_DEPTH);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   avail;
    logic [CW-1:0]   rem;
    logic            rd_q;
    logic            last_q;
    logic            burst_go;
    logic            flush_go;
    logic            space;
    logic            rd_last;
    logic            rd_en;
    logic            ob_in_ready;
    logic [OBW-1:0]  ob_count;

    // usedw wraps when full, so full stands in for DEPTH words.
    assign avail = bus.fifo_full ? DEPTH_C
                                 : {1'b0, bus.fifo_usedw};

    assign burst_go = (avail >= BURST_C);
    assign flush_go = bus.flush && (avail != '0) && !burst_go;
    assign rd_last  = (rem == CW'(1));

    // A read is only issued when its word is sure to find room.
    assign space = (ob_count + {{OBUF_PW{1'b0}}, rd_q}) < OB_FULL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (burst_go || flush_go) begin
                    state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rd_en && rd_last) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.out_valid && !rd_q) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        if (state == ST_BURST) begin
            rd_en = (rem != '0) && !bus.fifo_empty && space;
        end
        bus.fifo_rd = rd_en;
        bus.busy    = (state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem    <= '0;
            rd_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            rd_q   <= rd_en;
            last_q <= rd_en && rd_last;
            if (state == ST_IDLE) begin
                if (burst_go) begin
                    rem <= BURST_C;
                end else if (flush_go) begin
                    rem <= avail;
                end
            end else if (rd_en) begin
                rem <= rem - CW'(1);
            end
        end
    end

    fifo_rd_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_q),
        .in_ready  (ob_in_ready),
        .in_data   (bus.fifo_q),
        .in_last   (last_q),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .count     (ob_count)
    );

    a_obuf_room: assert property (
        @(posedge clk) disable iff (rst) rd_q |-> ob_in_ready
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl against a behavioural FIFO model.
module tb_fifo_rd_ctrl;
    import fifo_rd_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int BURST = 4;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    fifo_rd_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BURST (BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous FIFO model with registered read data.
    logic [7:0] fmem [8];
    logic [3:0] fcnt;
    logic [2:0] frp;
    logic [2:0] fwp;
    logic       push;
    logic       clr;
    logic [7:0] push_d;

    always @(posedge clk) begin
        if (clr) begin
            fcnt <= '0;
            frp  <= '0;
            fwp  <= '0;
        end else begin
            if (push) begin
                fmem[fwp] <= push_d;
                fwp <= fwp + 3'd1;
            end
            if (bus.fifo_rd) begin
                bus.fifo_q <= fmem[frp];
                frp <= frp + 3'd1;
            end
            fcnt <= fcnt + {3'b0, push} - {3'b0, bus.fifo_rd};
        end
    end

    assign bus.fifo_empty = (fcnt == 4'd0);
    assign bus.fifo_full  = (fcnt == 4'd8);
    assign bus.fifo_usedw = bus.fifo_full ? 3'd7 : fcnt[2:0];

    int         rd_cnt   = 0;
    int         rd_empty = 0;
    int         outst    = 0;
    int         max_out  = 0;
    logic       track    = 1'b0;
    logic [8:0] got [$];

    always @(posedge clk) begin
        if (rst) begin
            outst = 0;
        end else begin
            if (bus.fifo_rd) begin
                rd_cnt = rd_cnt + 1;
                outst = outst + 1;
                if (bus.fifo_empty) rd_empty = rd_empty + 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back({bus.out_last, bus.out_data});
                outst = outst - 1;
            end
            if (track && outst > max_out) max_out = outst;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] base, input logic [7:0] step,
                           input int n);
        logic [7:0] d;
        d = base;
        for (int i = 0; i < n; i++) begin
            push   = 1'b1;
            push_d = d;
            d = d + step;
            @(negedge clk);
        end
        push = 1'b0;
    endtask

    task automatic expect_stream(input string nm, input int g0,
                                 input logic [7:0] base, input int n,
                                 input int lmask);
        logic [8:0] e;
        chk({nm, " count"}, 32'(got.size() - g0), 32'(n));
        for (int i = 0; i < n; i++) begin
            e = {lmask[i], base + 8'(i)};
            if (g0 + i < got.size()) begin
                chk($sformatf("%s w%0d", nm, i), 32'(got[g0 + i]), 32'(e));
            end else begin
                checks++;
                errors++;
                $display("FAIL %s w%0d: got nothing expected 0x%0h",
                         nm, i, e);
            end
        end
    endtask

    typedef struct {
        logic       rdy;
        logic       fl;
        logic       e_rd;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    vec_t va [9];

    initial begin
        int g0;
        int rd0;
        int bad;
        logic [11:0] act;
        logic [11:0] exp;

        va[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        va[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        va[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        va[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
        va[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
        va[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1};
        va[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1};
        va[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        va[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        rst = 1'b1;
        clr = 1'b1;
        push = 1'b0;
        push_d = 8'h00;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_last", 32'(bus.out_last), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst out_data", 32'(bus.out_data), 32'd0);
        clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Single 4-word burst, cycle by cycle.
        preload(8'h11, 8'h11, 4);
        for (int i = 0; i < 9; i++) begin
            bus.out_ready = va[i].rdy;
            bus.flush = va[i].fl;
            #1;
            act = {bus.fifo_rd, bus.out_valid, bus.out_last, bus.busy,
                   va[i].e_valid ? bus.out_data : 8'h00};
            exp = {va[i].e_rd, va[i].e_valid, va[i].e_last, va[i].e_busy,
                   va[i].e_data};
            chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
            @(negedge clk);
        end

        // Short residue waits for flush; flush drops before reads.
        preload(8'hA1, 8'h01, 2);
        rd0 = rd_cnt;
        repeat (20) @(negedge clk);
        chk("noflush reads", 32'(rd_cnt - rd0), 32'd0);
        chk("noflush busy", 32'(bus.busy), 32'd0);
        g0 = got.size();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (12) @(negedge clk);
        chk("flush reads", 32'(rd_cnt - rd0), 32'd2);
        expect_stream("flush", g0, 8'hA1, 2, 'b10);
        chk("flush busy", 32'(bus.busy), 32'd0);

        // Full FIFO drains as two bursts.
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        preload(8'hC0, 8'h01, 8);
        rd0 = rd_cnt;
        g0 = got.size();
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("full reads", 32'(rd_cnt - rd0), 32'd8);
        expect_stream("full", g0, 8'hC0, 8, 'h88);
        chk("full busy", 32'(bus.busy), 32'd0);

        // Downstream stall: four reads, head word held.
        bus.out_ready = 1'b0;
        preload(8'hD1, 8'h01, 4);
        rd0 = rd_cnt;
        g0 = got.size();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid && bus.out_data !== 8'hD1) bad++;
            @(negedge clk);
        end
        chk("stall reads", 32'(rd_cnt - rd0), 32'd4);
        chk("stall valid", 32'(bus.out_valid), 32'd1);
        chk("stall data", 32'(bus.out_data), 32'hD1);
        chk("stall stable", 32'(bad), 32'd0);
        chk("stall accepted", 32'(got.size() - g0), 32'd0);
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        expect_stream("stall", g0, 8'hD1, 4, 'h8);
        chk("stall busy", 32'(bus.busy), 32'd0);

        // Reset after two reads of a burst.
        preload(8'hE1, 8'h01, 4);
        rd0 = rd_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst reads", 32'(rd_cnt - rd0), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        rd0 = rd_cnt;
        g0 = got.size();
        repeat (15) @(negedge clk);
        chk("postrst reads", 32'(rd_cnt - rd0), 32'd0);
        chk("postrst words", 32'(got.size() - g0), 32'd0);
        chk("postrst busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Alternating ready across a burst.
        track = 1'b1;
        preload(8'hF1, 8'h01, 4);
        rd0 = rd_cnt;
        g0 = got.size();
        for (int i = 0; i < 30; i++) begin
            bus.out_ready = (i % 2 == 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        track = 1'b0;
        chk("alt reads", 32'(rd_cnt - rd0), 32'd4);
        expect_stream("alt", g0, 8'hF1, 4, 'h8);
        chk("alt outstanding", 32'(max_out <= 5), 32'd1);

        // Burst condition outranks flush; residue then flushes.
        rst = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        preload(8'h61, 8'h01, 6);
        rd0 = rd_cnt;
        g0 = got.size();
        bus.flush = 1'b1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        bus.flush = 1'b0;
        chk("prio reads", 32'(rd_cnt - rd0), 32'd6);
        expect_stream("prio", g0, 8'h61, 6, 'h28);
        chk("prio busy", 32'(bus.busy), 32'd0);

        chk("read on empty", 32'(rd_empty), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
